// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and its environment.
// The environment drives the control inputs, and the sequencer returns pc, stage enables and status.
interface stage_sequencer_if #(
  parameter int PC_WIDTH  = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 start;
  logic                 stall;
  logic                 halt_instr;
  logic                 skip_mem;
  logic                 branch_taken;
  logic [PC_WIDTH-1:0]  branch_target;
  logic [PC_WIDTH-1:0]  pc;
  logic                 stage1;
  logic                 stage2;
  logic                 stage3;
  logic                 stage4;
  logic                 stage5;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output start, stall, halt_instr, skip_mem, branch_taken, branch_target,
    input  pc, stage1, stage2, stage3, stage4, stage5, busy, done, err, retired
  );

  modport slave (
    input  start, stall, halt_instr, skip_mem, branch_taken, branch_target,
    output pc, stage1, stage2, stage3, stage4, stage5, busy, done, err, retired
  );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the 5-stage MIPS core.
// It owns the pc, retired count and sticky error flag, and drives registered one-hot stage enables.
module stage_sequencer #(
  parameter int PC_WIDTH  = 4,
  parameter int PROG_LEN  = 9,
  parameter int CNT_WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  stage_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  // One extra bit so that pc+1 and the branch target compare against PROG_LEN without wrapping.
  localparam logic [PC_WIDTH:0] PROG_LEN_W = (PC_WIDTH+1)'(PROG_LEN);

  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic [4:0]           stage_q, stage_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [PC_WIDTH:0]    pc_inc_s;
  logic [PC_WIDTH:0]    target_ext_s;

  assign pc_inc_s     = {1'b0, pc_q} + (PC_WIDTH+1)'(1);
  assign target_ext_s = {1'b0, bus.branch_target};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
      stage_q   <= 5'b00000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      stage_q   <= stage_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          err_d     = 1'b0;
          retired_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        if (bus.stall) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.halt_instr) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (bus.skip_mem) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_MEMORY;
        end
      end
      S_MEMORY: begin
        if (bus.stall) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (retired_q != {CNT_WIDTH{1'b1}}) begin
          retired_d = retired_q + CNT_WIDTH'(1);
        end else begin
          retired_d = retired_q;
        end
        // An out-of-range target is an error: pc stays put and the program stops.
        if (bus.branch_taken) begin
          if (target_ext_s < PROG_LEN_W) begin
            pc_d    = bus.branch_target;
            state_d = S_FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        end else if (pc_inc_s < PROG_LEN_W) begin
          pc_d    = pc_inc_s[PC_WIDTH-1:0];
          state_d = S_FETCH;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode the upcoming state so the registered enables line up with the state register.
  always_comb begin
    stage_d = 5'b00000;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_FETCH:     begin stage_d = 5'b00001; busy_d = 1'b1; end
      S_DECODE:    begin stage_d = 5'b00010; busy_d = 1'b1; end
      S_EXECUTE:   begin stage_d = 5'b00100; busy_d = 1'b1; end
      S_MEMORY:    begin stage_d = 5'b01000; busy_d = 1'b1; end
      S_WRITEBACK: begin stage_d = 5'b10000; busy_d = 1'b1; end
      S_HALT:      begin done_d  = 1'b1; end
      default:     begin done_d  = 1'b0; end
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.err     = err_q;
  assign bus.retired = retired_q;
  assign bus.stage1  = stage_q[0];
  assign bus.stage2  = stage_q[1];
  assign bus.stage3  = stage_q[2];
  assign bus.stage4  = stage_q[3];
  assign bus.stage5  = stage_q[4];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
